// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
//
// Byte FIFO in front of a UART transmitter. A producer pushes bytes with
// wr_en/wr_data; a four-state drain FSM (IDLE, LOAD, REQ, DRAIN) pops one byte
// at a time into the registered TX_DATA output and handshakes it to the UART
// with transmit/busy.
//
// Parameters
//   DEPTH  FIFO entries, power of two, 4..256
//   AW     pointer address width, log2(DEPTH)
//
// Ports
//   CLK       in   clock, all state on the rising edge
//   RST       in   asynchronous active-low reset
//   wr_en     in   producer write strobe, one byte per cycle
//   wr_data   in   byte to enqueue
//   full      out  DEPTH bytes stored
//   empty     out  zero bytes stored
//   overflow  out  one-cycle pulse after a write attempted while full
//   busy      in   transmitter busy
//   transmit  out  transmit request, high only in REQ (decoded from state)
//   TX_DATA   out  byte presented to the transmitter, loaded only in LOAD
//   level     out  occupancy 0..DEPTH (only with UART_TX_QUEUE_LEVEL_EN)
//
// Optional feature macro: UART_TX_QUEUE_LEVEL_EN adds the level port and its
// occupancy counter; without it full/empty come from the pointers alone.
// -----------------------------------------------------------------------------
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          busy,
    output logic          transmit,
    output logic [7:0]    TX_DATA
`ifdef UART_TX_QUEUE_LEVEL_EN
    ,
    output logic [AW:0]   level
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_REQ   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        overflow_q, overflow_d;
    logic        push;
    logic        pop;

    logic [7:0]  mem [DEPTH];

    // A full FIFO drops the write; a pop in the same cycle does not rescue it
    // because full is evaluated from the pre-edge pointers.
    assign push = wr_en && !full;
    // The only pop point is LOAD, and LOAD is entered only when non-empty.
    assign pop  = (state_q == S_LOAD);

`ifdef UART_TX_QUEUE_LEVEL_EN
    logic [AW:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
`else
    // Extra wrap bit distinguishes full (same address, different lap) from
    // empty (identical pointers).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
`endif

    // Storage: plain array, written on push, read into the TX_DATA register.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Datapath next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        overflow_d = wr_en && full;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
            tx_data_d = mem[rd_ptr_q[AW-1:0]];
        end
    end

    // Drain FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!empty && !busy) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (busy) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Decoded from the state register only, so reset drops it immediately and
    // busy has no combinational path to it.
    assign transmit = (state_q == S_REQ);
    assign TX_DATA  = tx_data_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_queue
//
// Directed bench for uart_tx_queue. A vector table exercises the drain
// handshake cycle by cycle with busy driven directly; hand-written sequences
// cover fill/overflow, overflow during LOAD, simultaneous push/pop, wrap-around
// ordering and reset during REQ. A small transmitter model stands in for the
// UART in the sequences: it accepts a byte when transmit is seen, holds busy
// for a few cycles and records the byte for in-order comparison.
// Timing: inputs are driven and outputs sampled 1 time unit after each rising
// edge; the transmitter model acts 3 time units after the edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        CLK      = 1'b0;
    logic        RST      = 1'b0;
    logic        wr_en    = 1'b0;
    logic [7:0]  wr_data  = 8'h00;
    logic        busy     = 1'b0;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        transmit;
    logic [7:0]  TX_DATA;
`ifdef UART_TX_QUEUE_LEVEL_EN
    logic [AW:0] level;
`endif

    always #5 CLK = ~CLK;

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .busy     (busy),
        .transmit (transmit),
        .TX_DATA  (TX_DATA)
`ifdef UART_TX_QUEUE_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_level(input string name, input int exp);
`ifdef UART_TX_QUEUE_LEVEL_EN
        check(name, 32'(level), 32'(exp));
`endif
    endtask

    // Transmitter model (sole driver of busy).
    logic       sink_en    = 1'b0;
    logic       force_busy = 1'b0;
    logic       tb_busy    = 1'b0;
    int         sink_cnt   = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always @(posedge CLK) begin
        #3;
        if (!sink_en) begin
            busy = tb_busy;
        end else begin
            if (!RST) begin
                sink_cnt = 0;
            end else begin
                if (sink_cnt != 0) sink_cnt--;
                if (transmit && !busy && !force_busy) begin
                    rx_q.push_back(TX_DATA);
                    $display("tx byte %02h accepted", TX_DATA);
                    sink_cnt = 4;
                end
            end
            busy = force_busy || (sink_cnt != 0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST        = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        tb_busy    = 1'b0;
        force_busy = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        exp_q.push_back(d);
    endtask

    // Wait (bounded) for all expected bytes to leave, then compare in order.
    task automatic drain_check(input string name);
        int n;
        for (int c = 0; c < 3000; c++) begin
            if (rx_q.size() >= exp_q.size() && empty && !transmit && !busy) break;
            tick();
        end
        repeat (20) tick();
        check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        $display("%s: %0d bytes received", name, rx_q.size());
        rx_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       bsy;
        logic       e_tx;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int  ovf_seen;
        int  tx_seen;
        int  waited;

        //           wr    d      bsy   tx    empty full  ovf   data
        tbl[0]  = '{1'b1, 8'h6F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // write
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // IDLE detect -> LOAD
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h6F}; // REQ
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h6F}; // wait busy
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6F}; // DRAIN
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6F};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6F}; // IDLE
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6F}; // stays IDLE
        tbl[8]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h6F};
        tbl[9]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h6F}; // busy holds IDLE
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h6F}; // LOAD
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5}; // REQ A5
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5}; // DRAIN
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5}; // IDLE
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5}; // LOAD
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A}; // REQ 5A
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A}; // DRAIN
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A}; // IDLE

        // ---- reset state (sampled while RST is still low) ----
        RST = 1'b0;
        tick();
        tick();
        check("rst_transmit", 32'(transmit), 32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_tx_data",  32'(TX_DATA),  32'h00);
        check_level("rst_level", 0);
        $display("reset: transmit=%0b empty=%0b full=%0b TX_DATA=%02h", transmit, empty, full, TX_DATA);

        // ---- vector table: drain handshake with busy driven directly ----
        do_reset();
        sink_en = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wr_en   = tbl[i].wr;
            wr_data = tbl[i].d;
            tb_busy = tbl[i].bsy;
            tick();
            check($sformatf("vec%0d_transmit", i), 32'(transmit), 32'(tbl[i].e_tx));
            check($sformatf("vec%0d_empty", i),    32'(empty),    32'(tbl[i].e_empty));
            check($sformatf("vec%0d_full", i),     32'(full),     32'(tbl[i].e_full));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
            check($sformatf("vec%0d_tx_data", i),  32'(TX_DATA),  32'(tbl[i].e_data));
            $display("vec%0d wr=%0b d=%02h busy=%0b -> transmit=%0b empty=%0b full=%0b ovf=%0b TX_DATA=%02h",
                     i, tbl[i].wr, tbl[i].d, tbl[i].bsy, transmit, empty, full, overflow, TX_DATA);
        end
        wr_en   = 1'b0;
        tb_busy = 1'b0;

        // ---- fill to full with busy forced, then overflow ----
        sink_en = 1'b1;
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i + 1));
        check("fill_full",  32'(full),     32'd1);
        check("fill_empty", 32'(empty),    32'd0);
        check_level("fill_level", DEPTH);
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        tick();
        wr_en   = 1'b0;
        check("ovf_pulse",      32'(overflow), 32'd1);
        check("ovf_still_full", 32'(full),     32'd1);
        check_level("ovf_level", DEPTH);
        tick();
        check("ovf_pulse_end",  32'(overflow), 32'd0);
        $display("overflow write AA: pulse observed and cleared");
        force_busy = 1'b0;
        drain_check("fill_drain");

        // ---- overflow while FSM is in LOAD ----
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_byte(8'h30 + 8'(i));
        force_busy = 1'b0;
        tick();                                   // IDLE -> LOAD
        check("load_full",     32'(full),     32'd1);
        check("load_transmit", 32'(transmit), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();                                   // LOAD pops; write dropped
        wr_en   = 1'b0;
        check("load_ovf",      32'(overflow), 32'd1);
        check("load_pop_full", 32'(full),     32'd0);
        check("load_req",      32'(transmit), 32'd1);
        check("load_tx_data",  32'(TX_DATA),  32'h30);
        check_level("load_level", DEPTH - 1);
        tick();
        check("load_ovf_end",  32'(overflow), 32'd0);
        drain_check("load_drain");

        // ---- simultaneous push and pop at occupancy 5 ----
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
        force_busy = 1'b0;
        tick();                                   // IDLE -> LOAD
        push_byte(8'h45);                         // push during the pop edge
        check("pp_full",     32'(full),     32'd0);
        check("pp_empty",    32'(empty),    32'd0);
        check("pp_overflow", 32'(overflow), 32'd0);
        check("pp_tx_data",  32'(TX_DATA),  32'h40);
        check_level("pp_level", 5);
        drain_check("pp_drain");

        // ---- 40 bytes paced to avoid full, two pointer wraps ----
        do_reset();
        ovf_seen = 0;
        for (int i = 0; i < 40; i++) begin
            waited = 0;
            while (full && waited < 200) begin
                tick();
                waited++;
            end
            push_byte(8'(i));
            if (overflow) ovf_seen++;
        end
        check("wrap_no_overflow", 32'(ovf_seen), 32'd0);
        drain_check("wrap_drain");

        // ---- reset asserted while in REQ with 3 bytes queued ----
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'h70 + 8'(i));
        force_busy = 1'b0;
        waited = 0;
        while (!transmit && waited < 20) begin
            tick();
            waited++;
        end
        check("rreq_reached", 32'(transmit), 32'd1);
        check("rreq_tx_data", 32'(TX_DATA),  32'h70);
        RST = 1'b0;
        #1;
        check("rreq_transmit_drop", 32'(transmit), 32'd0);
        check("rreq_empty",         32'(empty),    32'd1);
        check("rreq_tx_clear",      32'(TX_DATA),  32'h00);
        check_level("rreq_level", 0);
        tick();
        RST = 1'b1;
        tx_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (transmit) tx_seen++;
        end
        check("rreq_quiet_transmit", 32'(tx_seen),     32'd0);
        check("rreq_quiet_empty",    32'(empty),       32'd1);
        check("rreq_no_rx",          32'(rx_q.size()), 32'd0);
        $display("reset during REQ: transmit high in %0d of 100 cycles afterwards", tx_seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
